// File: rtl/mult_control_if.sv
// Handshake bundle between the shift-add multiplier control FSM and its ACC/RISC neighbours.
// The slave modport is the controller; the master modport is whatever drives St/M/Ack.
interface mult_control_if;
   logic St;
   logic M;
   logic Ack;
   logic Load;
   logic Ad;
   logic Sh;
   logic Done;
   logic Busy;

   modport master (output St, M, Ack, input  Load, Ad, Sh, Done, Busy);
   modport slave  (input  St, M, Ack, output Load, Ad, Sh, Done, Busy);
endinterface

// File: rtl/mult_control.sv
// Shift-add multiplier control FSM: sequences ACC Load/Ad/Sh per multiplier bit and flags Done.
// Optional MULT_CTRL_DONE_HOLD_EN: Done is held until a rising edge with Ack=1.
module mult_control #(
   parameter int N = 4
) (
   input  logic          Clk,
   input  logic          rst,
   mult_control_if.slave bus
);

   localparam int            KW     = $clog2(N) + 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      EVAL,
      SHIFT,
      DONE
   } state_t;

   state_t        state, state_next;
   logic [KW-1:0] k, k_next;
   logic          load, ad, sh, done;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         k     <= '0;
      end else begin
         state <= state_next;
         k     <= k_next;
      end
   end

   // NOTE: every output of this block is defaulted first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      k_next     = k;
      load       = 1'b0;
      ad         = 1'b0;
      sh         = 1'b0;
      done       = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.St) state_next = LOAD;
         end
         LOAD: begin
            load       = 1'b1;
            k_next     = '0;
            state_next = EVAL;
         end
         EVAL: begin
            // Mealy on M: a set bit adds first and shifts in SHIFT; a clear bit shifts right here
            if (bus.M) begin
               ad         = 1'b1;
               state_next = SHIFT;
            end else begin
               sh     = 1'b1;
               k_next = k + 1'b1;
               if (k == K_LAST) state_next = DONE;
            end
         end
         SHIFT: begin
            sh         = 1'b1;
            k_next     = k + 1'b1;
            state_next = (k == K_LAST) ? DONE : EVAL;
         end
         DONE: begin
            done = 1'b1;
`ifdef MULT_CTRL_DONE_HOLD_EN
            if (bus.Ack) state_next = IDLE;
`else
            state_next = IDLE;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

`ifndef MULT_CTRL_DONE_HOLD_EN
   // Ack only matters when Done is held; tie it off here so the port stays consumed
   logic unused_ack;
   assign unused_ack = bus.Ack;
`endif

   assign bus.Load = load;
   assign bus.Ad   = ad;
   assign bus.Sh   = sh;
   assign bus.Done = done;
   assign bus.Busy = (state != IDLE);

endmodule
